// File: rtl/execute_stage_if.sv
// ---------------------------------------------------------------------------
// execute_stage_if
// ID/EX inputs, hazard-unit controls and EX/MEM outputs of the EX stage.
// master: the upstream driver (decode/hazard side), slave: the execute stage.
// ---------------------------------------------------------------------------
interface execute_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   // hazard unit controls
   logic              StallE;
   logic              FlushE;
   // ID/EX controls
   logic              RegWriteE;
   logic              MemWriteE;
   logic              ResultSrcE;
   logic              BranchE;
   logic              ALUSrcE;
   logic [2:0]        ALUControlE;
   // ID/EX data
   logic [DATA_W-1:0] RD1_E;
   logic [DATA_W-1:0] RD2_E;
   logic [DATA_W-1:0] Imm_Ext_E;
   logic [DATA_W-1:0] PCE;
   logic [DATA_W-1:0] PCPlus4E;
   logic [REG_W-1:0]  RD_E;
   // forwarding
   logic [1:0]        ForwardA_E;
   logic [1:0]        ForwardB_E;
   logic [DATA_W-1:0] ResultW;
   // branch resolution (combinational)
   logic              PCSrcE;
   logic [DATA_W-1:0] PCTargetE;
   // EX/MEM register
   logic              RegWriteM;
   logic              MemWriteM;
   logic              ResultSrcM;
   logic [REG_W-1:0]  RD_M;
   logic [DATA_W-1:0] ALUResultM;
   logic [DATA_W-1:0] WriteDataM;
   logic [DATA_W-1:0] PCPlus4M;

   modport master (
      output StallE, FlushE, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE,
             ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
             ForwardA_E, ForwardB_E, ResultW,
      input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
             ALUResultM, WriteDataM, PCPlus4M
   );

   modport slave (
      input  StallE, FlushE, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE,
             ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
             ForwardA_E, ForwardB_E, ResultW,
      output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
             ALUResultM, WriteDataM, PCPlus4M
   );
endinterface

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// RV32I EX stage: operand forwarding, ALU, beq resolution, branch target and
// the EX/MEM pipeline register (stall = hold, flush = bubble).
// Optional macro EX_FORWARD_EN: when defined, ForwardA_E/ForwardB_E select
// between register data, ResultW and the EX/MEM ALU result; when undefined
// the operands come straight from RD1_E/RD2_E.
// ---------------------------------------------------------------------------
module execute_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic         clk,
   input  logic         rst,
   execute_stage_if.slave ex
);

   logic [DATA_W-1:0] fwd_a_s;
   logic [DATA_W-1:0] fwd_b_s;
   logic [DATA_W-1:0] src_b_s;
   logic [DATA_W-1:0] alu_s;
   logic              zero_s;

   logic              reg_write_m_r;
   logic              mem_write_m_r;
   logic              result_src_m_r;
   logic [REG_W-1:0]  rd_m_r;
   logic [DATA_W-1:0] alu_result_m_r;
   logic [DATA_W-1:0] write_data_m_r;
   logic [DATA_W-1:0] pc_plus4_m_r;

`ifdef EX_FORWARD_EN
   // Operand A forwarding select (00/11 fall back to register data)
   always_comb begin
      fwd_a_s = ex.RD1_E;
      case (ex.ForwardA_E)
         2'b01:   fwd_a_s = ex.ResultW;
         2'b10:   fwd_a_s = alu_result_m_r;
         default: fwd_a_s = ex.RD1_E;
      endcase
   end

   // Operand B forwarding select (00/11 fall back to register data)
   always_comb begin
      fwd_b_s = ex.RD2_E;
      case (ex.ForwardB_E)
         2'b01:   fwd_b_s = ex.ResultW;
         2'b10:   fwd_b_s = alu_result_m_r;
         default: fwd_b_s = ex.RD2_E;
      endcase
   end
`else
   // Without forwarding the select lines and ResultW have no effect
   logic unused_fwd_s;
   assign unused_fwd_s = ^{ex.ForwardA_E, ex.ForwardB_E, ex.ResultW};
   assign fwd_a_s      = ex.RD1_E;
   assign fwd_b_s      = ex.RD2_E;
`endif

   assign src_b_s = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_b_s;

   // ALU: unused op codes yield zero so beq never sees a stale value
   always_comb begin
      alu_s = {DATA_W{1'b0}};
      case (ex.ALUControlE)
         3'b000:  alu_s = fwd_a_s + src_b_s;
         3'b001:  alu_s = fwd_a_s + ~src_b_s + {{(DATA_W-1){1'b0}}, 1'b1};
         3'b010:  alu_s = fwd_a_s & src_b_s;
         3'b011:  alu_s = fwd_a_s | src_b_s;
         3'b101:  alu_s = {{(DATA_W-1){1'b0}}, ($signed(fwd_a_s) < $signed(src_b_s))};
         default: alu_s = {DATA_W{1'b0}};
      endcase
   end

   assign zero_s       = (alu_s == {DATA_W{1'b0}});
   assign ex.PCSrcE    = ex.BranchE & zero_s;
   assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

   // EX/MEM register: reset > flush (bubble) > stall (hold) > load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_m_r  <= 1'b0;
         mem_write_m_r  <= 1'b0;
         result_src_m_r <= 1'b0;
         rd_m_r         <= {REG_W{1'b0}};
         alu_result_m_r <= {DATA_W{1'b0}};
         write_data_m_r <= {DATA_W{1'b0}};
         pc_plus4_m_r   <= {DATA_W{1'b0}};
      end else if (ex.FlushE) begin
         reg_write_m_r  <= 1'b0;
         mem_write_m_r  <= 1'b0;
         result_src_m_r <= 1'b0;
         rd_m_r         <= {REG_W{1'b0}};
         alu_result_m_r <= {DATA_W{1'b0}};
         write_data_m_r <= {DATA_W{1'b0}};
         pc_plus4_m_r   <= {DATA_W{1'b0}};
      end else if (ex.StallE) begin
         reg_write_m_r  <= reg_write_m_r;
         mem_write_m_r  <= mem_write_m_r;
         result_src_m_r <= result_src_m_r;
         rd_m_r         <= rd_m_r;
         alu_result_m_r <= alu_result_m_r;
         write_data_m_r <= write_data_m_r;
         pc_plus4_m_r   <= pc_plus4_m_r;
      end else begin
         // writes to x0 are dropped here so later stages never see them
         reg_write_m_r  <= ex.RegWriteE & (ex.RD_E != {REG_W{1'b0}});
         mem_write_m_r  <= ex.MemWriteE;
         result_src_m_r <= ex.ResultSrcE;
         rd_m_r         <= ex.RD_E;
         alu_result_m_r <= alu_s;
         write_data_m_r <= fwd_b_s;
         pc_plus4_m_r   <= ex.PCPlus4E;
      end
   end

   assign ex.RegWriteM  = reg_write_m_r;
   assign ex.MemWriteM  = mem_write_m_r;
   assign ex.ResultSrcM = result_src_m_r;
   assign ex.RD_M       = rd_m_r;
   assign ex.ALUResultM = alu_result_m_r;
   assign ex.WriteDataM = write_data_m_r;
   assign ex.PCPlus4M   = pc_plus4_m_r;

endmodule
